// File: rtl/chirp_dds_responder.sv
// Linear-FM chirp responder for the FMC150 DAC path: answers the pulse controller's
// init/enable handshake and streams a frequency word plus phase-accumulator sample per clock.
module chirp_dds_responder #(
    parameter int PHASE_W     = 16,
    parameter int READY_DELAY = 16
) (
    input  logic                clk_fmc150,
    input  logic                aresetn,
    input  logic                dac_ready,
    input  logic [127:0]        chirp_parameters_in,
    input  logic                chirp_init,
    input  logic                chirp_enable,
    output logic                chirp_ready,
    output logic                chirp_active,
    output logic                chirp_done,
    output logic                chirp_abort,
    output logic                dds_valid,
    output logic [31:0]         freq_out,
    output logic [PHASE_W-1:0]  phase_out
);

    localparam int CNT_W = $clog2(READY_DELAY + 1);
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(READY_DELAY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t state, state_n;

    logic [CNT_W-1:0] startup_cnt;
    logic             startup_sat;

    logic [31:0] coef_q,  coef_n;
    logic [31:0] cmax_q,  cmax_n;
    logic [31:0] count_q, count_n;
    logic [31:0] freq_q,  freq_n;
    logic [31:0] acc_q,   acc_n;

    logic               ready_n;
    logic               valid_n;
    logic               active_n;
    logic               done_n;
    logic               abort_n;
    logic [31:0]        freq_out_n;
    logic [PHASE_W-1:0] phase_out_n;

    // The top word of the parameter bus carries nothing for this block.
    logic unused_param_bits;
    assign unused_param_bits = ^chirp_parameters_in[127:96];

    assign startup_sat = (startup_cnt == READY_MAX);

    always_comb begin
        state_n     = state;
        coef_n      = coef_q;
        cmax_n      = cmax_q;
        count_n     = count_q;
        freq_n      = freq_q;
        acc_n       = acc_q;
        valid_n     = 1'b0;
        active_n    = 1'b0;
        done_n      = 1'b0;
        abort_n     = 1'b0;
        freq_out_n  = freq_out;
        phase_out_n = phase_out;

        case (state)
            IDLE: begin
                if (chirp_init && chirp_enable && chirp_ready) begin
                    state_n = ACTIVE;
                    coef_n  = chirp_parameters_in[63:32];
                    cmax_n  = chirp_parameters_in[31:0];
                    freq_n  = chirp_parameters_in[95:64];
                    count_n = 32'd0;
                    acc_n   = 32'd0;
                end
            end

            ACTIVE: begin
                if (!chirp_enable) begin
                    abort_n = 1'b1;
                    state_n = HOLD;
                end else begin
                    valid_n     = 1'b1;
                    active_n    = 1'b1;
                    freq_out_n  = freq_q;
                    phase_out_n = acc_q[31:32-PHASE_W];
                    // Sample k emits the values before this update, so phase lags freq by one term.
                    acc_n       = acc_q + freq_q;
                    freq_n      = freq_q + coef_q;
                    count_n     = count_q + 32'd1;
                    if (count_q == cmax_q) begin
                        state_n = DONE;
                    end
                end
            end

            DONE: begin
                done_n  = 1'b1;
                state_n = HOLD;
            end

            HOLD: begin
                // Wait for the controller to drop enable so a lagging enable cannot retrigger.
                if (!chirp_enable) begin
                    state_n = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase

        // Based on the next state so ready is never seen high outside IDLE.
        ready_n = (state_n == IDLE) && startup_sat && dac_ready;
    end

    always_ff @(posedge clk_fmc150) begin
        if (!aresetn) begin
            state        <= IDLE;
            startup_cnt  <= '0;
            coef_q       <= 32'd0;
            cmax_q       <= 32'd0;
            count_q      <= 32'd0;
            freq_q       <= 32'd0;
            acc_q        <= 32'd0;
            chirp_ready  <= 1'b0;
            chirp_active <= 1'b0;
            chirp_done   <= 1'b0;
            chirp_abort  <= 1'b0;
            dds_valid    <= 1'b0;
            freq_out     <= 32'd0;
            phase_out    <= '0;
        end else begin
            state        <= state_n;
            if (!startup_sat) begin
                startup_cnt <= startup_cnt + 1'b1;
            end
            coef_q       <= coef_n;
            cmax_q       <= cmax_n;
            count_q      <= count_n;
            freq_q       <= freq_n;
            acc_q        <= acc_n;
            chirp_ready  <= ready_n;
            chirp_active <= active_n;
            chirp_done   <= done_n;
            chirp_abort  <= abort_n;
            dds_valid    <= valid_n;
            freq_out     <= freq_out_n;
            phase_out    <= phase_out_n;
        end
    end

endmodule

// File: doc/chirp_dds_responder.md
Name: chirp_dds_responder

Overview:
- DAC-side responder to the radar pulse controller's chirp handshake.
- Accepts chirp_init/chirp_enable and returns chirp_ready, chirp_active and chirp_done.
- Generates a linear-FM chirp as a frequency word and phase-accumulator sample stream for the FMC150 DAC path, all in the clk_fmc150 domain.
- Chirp parameters are latched at each chirp start.

Parameters:
- PHASE_W, 16, width of phase_out (top bits of the 32-bit accumulator).
- READY_DELAY, 16, clk_fmc150 cycles after reset release before chirp_ready may assert (minimum 1).

Ports:
- clk_fmc150  in  1  245.76 MHz DAC clock.
- aresetn  in  1  synchronous, active-low reset; clock clk_fmc150.
- dac_ready  in  1  DAC/FMC150 path ready (level).
- chirp_parameters_in  in  128  [95:64] freq_offset, [63:32] tuning_coef, [31:0] counter_max; [127:96] unused.
- chirp_init  in  1  single-cycle start request.
- chirp_enable  in  1  level, high while the controller permits chirping.
- chirp_ready  out  1  high when a chirp can be accepted.
- chirp_active  out  1  high while samples are being produced.
- chirp_done  out  1  single-cycle pulse at normal completion.
- chirp_abort  out  1  single-cycle pulse when a chirp is cut short by chirp_enable falling.
- dds_valid  out  1  sample strobe.
- freq_out  out  32  instantaneous frequency word of the current sample.
- phase_out  out  PHASE_W  accumulator bits [31:32-PHASE_W] of the current sample.

Behaviour:
- Reset: all outputs 0; state IDLE; startup counter cleared; latched parameters 0.
- Startup counter increments after reset release and saturates at READY_DELAY.
- chirp_ready = (state==IDLE) & startup counter saturated & dac_ready. It is registered with 1-cycle lag; it is never high outside IDLE.
- States:
  - IDLE -> ACTIVE: on chirp_init & chirp_enable & chirp_ready sampled high.
    - Latch offset, coef and cmax from chirp_parameters_in.
    - count=0; freq=offset; acc=0.
    - chirp_init in IDLE with chirp_enable low or chirp_ready low is ignored.
  - ACTIVE, each cycle:
    - dds_valid=1, chirp_active=1.
    - freq_out=freq, phase_out=acc[31:32-PHASE_W].
    - Then acc<=acc+freq, freq<=freq+coef, count<=count+1 (all modulo 2^32; no multiplier).
    - Exactly cmax+1 samples. On the sample with count==cmax -> DONE.
    - Sample k therefore has freq = offset + k*coef mod 2^32, and phase = sum_{j<k} freq_j mod 2^32.
  - ACTIVE abort: if chirp_enable is sampled low in ACTIVE, no sample is emitted that cycle.
    - dds_valid and chirp_active fall; chirp_abort pulses 1 cycle; go to HOLD.
    - chirp_done is not asserted.
  - DONE: one cycle. chirp_done=1, dds_valid=0, chirp_active=0 -> HOLD.
  - HOLD: wait until chirp_enable is sampled low -> IDLE. This prevents retrigger while the controller's enable lags done.
- Timing:
  - chirp_init sampled at edge N -> first dds_valid cycle follows edge N+1.
  - chirp_active and dds_valid are identical and contiguous.
  - chirp_done follows the last valid sample by exactly one cycle.
- chirp_init outside IDLE is ignored.
- chirp_parameters_in changes during ACTIVE/DONE/HOLD have no effect until the next start.
- cmax=0: single sample, then DONE. cmax=0xFFFFFFFF: count compares equal at the top value, so count never wraps before completion.
- dac_ready falling during ACTIVE does not stop the chirp; it only gates the next start.
- Reset mid-chirp: next cycle all outputs 0, state IDLE, and chirp_ready held low for READY_DELAY cycles again.
- chirp_init and chirp_enable come from the controller's clk_fmc150 registers: no synchronizers are needed; they are sampled directly.

Test Plan:
- Basic chirp: READY_DELAY elapsed, dac_ready=1, cmax=3, coef=1, offset=0x600; pulse init with enable high.
  - Required: 4 valid cycles starting 1 cycle after init.
  - freq_out = 0x600, 0x601, 0x602, 0x603.
  - Accumulator values 0, 0x600, 0xC01, 0x1203 (phase_out = top 16 bits).
  - chirp_done pulses one cycle after the last sample.
  - ready returns only after enable is dropped.
- Single sample: cmax=0 -> exactly 1 dds_valid cycle with freq_out=offset and phase_out=0, then chirp_done.
- Abort: cmax=100; drop chirp_enable after the 10th valid sample.
  - Required: exactly 10 samples, chirp_abort pulse, no chirp_done.
  - IDLE with ready high next cycle, since enable is already low.
- Gating:
  - init with enable=0 -> ignored.
  - init during ACTIVE -> ignored.
  - init before READY_DELAY cycles or with dac_ready=0 -> no valid output, ready stays 0.
- Parameter latch and wrap:
  - Change chirp_parameters_in mid-chirp -> sample sequence unchanged.
  - coef=0x80000000, offset=0x80000000, cmax=2 -> freq_out = 0x80000000, 0x00000000, 0x80000000.
- Reset mid-chirp: assert aresetn=0 during ACTIVE -> next cycle all outputs 0; chirp_ready low for READY_DELAY cycles after release.
